// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared encodings and helpers for the Quad-SPI receive path
//
// Contents:
//   spi_mode_e      : IO width encoding (single/dual/quad; 3 is reserved and behaves as single)
//   rx_state_e      : receive FSM states
//   RX_FIFO_DEPTH   : depth of the receive FIFO
//   bits_per_sample : IO bits captured per sample strobe for a given mode
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE_SINGLE = 2'd0,
    SPI_MODE_DUAL   = 2'd1,
    SPI_MODE_QUAD   = 2'd2,
    SPI_MODE_RSVD   = 2'd3
  } spi_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PUSH   = 2'd2,
    FINISH = 2'd3
  } rx_state_e;

  localparam int RX_FIFO_DEPTH = 261;

  function automatic logic [3:0] bits_per_sample(input logic [1:0] mode);
    case (mode)
      SPI_MODE_DUAL: return 4'd2;
      SPI_MODE_QUAD: return 4'd4;
      default:       return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// rtl/spi_rx_shifter.sv - MSB-first byte assembler with 1/2/4-bit insert
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart assembly of a new byte (transfer start)
//   sample_en   : capture IO lines this cycle
//   bits        : bits inserted per sample (1, 2 or 4)
//   io_in       : SPI IO[3:0]; single mode takes IO1 (MISO)
//   data        : shift register contents; holds the full byte after the final sample
//   byte_ready  : high during the sample that completes a byte
module spi_rx_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       sample_en,
  input  logic [3:0] bits,
  input  logic [3:0] io_in,
  output logic [7:0] data,
  output logic       byte_ready
);

  logic [3:0] bit_cnt;
  logic [7:0] shifted;

  always_comb begin
    case (bits)
      4'd2:    shifted = {data[5:0], io_in[1:0]};
      4'd4:    shifted = {data[3:0], io_in};
      default: shifted = {data[6:0], io_in[1]};
    endcase
  end

  // Counting bits rather than samples keeps one comparator for all modes.
  assign byte_ready = sample_en && ((bit_cnt + bits) == 4'd8);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data    <= 8'd0;
      bit_cnt <= 4'd0;
    end else if (sample_en) begin
      data    <= shifted;
      bit_cnt <= byte_ready ? 4'd0 : bit_cnt + bits;
    end
  end

endmodule

// File: rtl/spi_rx_deserializer.sv
// rtl/spi_rx_deserializer.sv - Quad-SPI receive shift stage feeding the RX FIFO
//
// Build option: SPI_RX_STALL_EN - hold in PUSH with stall=1 while the FIFO is
//   full instead of dropping the byte and setting overflow.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle pulse; latches mode and rx_len (ignored while busy)
//   mode         : 0 single, 1 dual, 2 quad, 3 treated as single
//   rx_len       : bytes to receive (0 legal)
//   sample_en    : IO lines valid this cycle
//   io_in        : SPI IO[3:0]
//   fifo_full    : RX FIFO full
//   fifo_wr_en   : FIFO write strobe, fifo_data valid with it
//   fifo_data    : received byte
//   busy         : transfer in progress (covers the done cycle)
//   done         : one-cycle completion pulse
//   overflow     : sticky, a byte met a full FIFO; cleared by start
//   byte_cnt     : bytes completed in the current transfer
//   stall        : SCK hold request
module spi_rx_deserializer
  import spi_pkg::*;
#(
  parameter int LEN_W   = 9,
  parameter int MAX_LEN = RX_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] rx_len,
  input  logic             sample_en,
  input  logic [3:0]       io_in,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_data,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [LEN_W-1:0] byte_cnt,
  output logic             stall
);

  if (MAX_LEN >= (1 << LEN_W)) begin : g_bad_max_len
    $error("MAX_LEN does not fit in LEN_W bits");
  end

  rx_state_e        state;
  logic [3:0]       bits_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_next;
  logic             accept;
  logic             shift_en;
  logic             byte_ready;
  logic             push_advance;
  logic [7:0]       byte_data;

  // busy stays high through the done cycle, which is what rejects a start
  // arriving together with done.
  assign accept   = (state == IDLE) && start && !busy;
  assign shift_en = (state == SHIFT) && sample_en;
  assign cnt_next = byte_cnt + LEN_W'(1);

  spi_rx_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .sample_en  (shift_en),
    .bits       (bits_q),
    .io_in      (io_in),
    .data       (byte_data),
    .byte_ready (byte_ready)
  );

  // The FIFO handshake is combinational so a full flag that drops is seen
  // in the same cycle the write goes out.
  assign fifo_wr_en = (state == PUSH) && !fifo_full;
  assign fifo_data  = byte_data;

`ifdef SPI_RX_STALL_EN
  assign push_advance = !fifo_full;
  assign stall        = (state == PUSH) && fifo_full;
`else
  assign push_advance = 1'b1;
  assign stall        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bits_q   <= 4'd1;
      len_q    <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bits_q   <= bits_per_sample(mode);
            len_q    <= rx_len;
            byte_cnt <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= (rx_len == '0) ? FINISH : SHIFT;
          end
        end
        SHIFT: begin
          if (byte_ready) state <= PUSH;
        end
        PUSH: begin
          if (push_advance) begin
            if (fifo_full) overflow <= 1'b1;
            byte_cnt <= cnt_next;
            if (cnt_next == len_q) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        FINISH: begin
          // Arriving from PUSH, done is already up; a zero-length transfer
          // raises it here, one cycle later.
          if (!done) done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// tb/tb_spi_rx_deserializer.sv - randomized self-checking bench for spi_rx_deserializer
module tb_spi_rx_deserializer;

  localparam int LEN_W = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] rx_len;
  logic             sample_en;
  logic [3:0]       io_in;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [7:0]       fifo_data;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [LEN_W-1:0] byte_cnt;
  logic             stall;

  int checks = 0;
  int errors = 0;
  int xbytes[$];
  bit xfull[$];

  always #5 clk = ~clk;

  spi_rx_deserializer #(.LEN_W(LEN_W), .MAX_LEN(261)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .rx_len     (rx_len),
    .sample_en  (sample_en),
    .io_in      (io_in),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .byte_cnt   (byte_cnt),
    .stall      (stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drives one transfer of len bytes (values in xbytes, full flags in xfull)
  // and checks every cycle against the expected protocol.
  task automatic run_xfer(input logic [1:0] m, input int len);
    int k;
    int spb;
    int chunk;
    int gap;
    bit ovf;
    ovf = 1'b0;
    k   = (m == 2'd2) ? 4 : (m == 2'd1) ? 2 : 1;
    spb = 8 / k;

    start = 1'b1; mode = m; rx_len = LEN_W'(len);
    sample_en = 1'b0; fifo_full = 1'b0;
    step();
    start = 1'b0; mode = 2'($urandom); rx_len = LEN_W'($urandom);
    settle();
    chk("busy_after_start", busy, 1);
    chk("cnt_cleared", byte_cnt, 0);
    chk("ovf_cleared", overflow, 0);

    for (int b = 0; b < len; b++) begin
      for (int s = 0; s < spb; s++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          sample_en = 1'b0;
          io_in     = 4'($urandom);
          start     = ($urandom_range(0, 3) == 0);
          mode      = 2'($urandom);
          rx_len    = LEN_W'($urandom);
          settle();
          chk("no_wr_shift", fifo_wr_en, 0);
          chk("busy_shift", busy, 1);
          step();
        end
        start = 1'b0;
        chunk = (xbytes[b] >> (8 - k * (s + 1))) & ((1 << k) - 1);
        io_in = 4'($urandom);
        if (k == 1)      io_in[1]   = chunk[0];
        else if (k == 2) io_in[1:0] = chunk[1:0];
        else             io_in      = chunk[3:0];
        sample_en = 1'b1;
        settle();
        chk("no_wr_sample", fifo_wr_en, 0);
        step();
      end
      // Push cycle: stray samples here must not disturb the next byte.
      sample_en = 1'($urandom_range(0, 1));
      io_in     = 4'($urandom);
      fifo_full = xfull[b];
`ifdef SPI_RX_STALL_EN
      if (xfull[b]) begin
        gap = $urandom_range(1, 3);
        for (int h = 0; h < gap; h++) begin
          settle();
          chk("stall_hi", stall, 1);
          chk("no_wr_full", fifo_wr_en, 0);
          step();
        end
        fifo_full = 1'b0;
      end
      settle();
      chk("stall_lo", stall, 0);
      chk("wr_en", fifo_wr_en, 1);
      chk("wr_data", fifo_data, xbytes[b]);
`else
      settle();
      chk("stall_lo", stall, 0);
      chk("wr_en", fifo_wr_en, !xfull[b]);
      if (!xfull[b]) chk("wr_data", fifo_data, xbytes[b]);
      if (xfull[b]) ovf = 1'b1;
`endif
      step();
      sample_en = 1'b0; fifo_full = 1'b0;
      settle();
      chk("byte_cnt", byte_cnt, b + 1);
      chk("overflow", overflow, ovf);
      chk("no_wr_after_push", fifo_wr_en, 0);
    end

    if (len == 0) begin
      settle();
      chk("done_early", done, 0);
      chk("busy_zero", busy, 1);
      step();
    end
    // Done cycle: a start here must be ignored.
    start = 1'b1; mode = 2'($urandom); rx_len = LEN_W'(1);
    settle();
    chk("done", done, 1);
    chk("busy_done", busy, 1);
    chk("final_cnt", byte_cnt, len);
    chk("final_ovf", overflow, ovf);
    chk("no_wr_done", fifo_wr_en, 0);
    step();
    start = 1'b0;
    settle();
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("cnt_hold", byte_cnt, len);
    step();
    settle();
    chk("start_with_done_ignored", busy, 0);
  endtask

  task automatic fill_random(input int len, input int full_pct);
    xbytes.delete();
    xfull.delete();
    for (int i = 0; i < len; i++) begin
      xbytes.push_back($urandom_range(0, 255));
      xfull.push_back($urandom_range(0, 99) < full_pct);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; rx_len = '0;
    sample_en = 1'b0; io_in = 4'd0; fifo_full = 1'b0;
    step();
    step();
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", byte_cnt, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b0;
    step();

    xbytes = '{32'hA5, 32'hF0}; xfull = '{1'b0, 1'b0};
    run_xfer(2'd0, 2);
    xbytes = '{32'h12, 32'h34, 32'h56}; xfull = '{1'b0, 1'b0, 1'b0};
    run_xfer(2'd2, 3);
    xbytes = '{32'hC9}; xfull = '{1'b0};
    run_xfer(2'd1, 1);
    xbytes.delete(); xfull.delete();
    run_xfer(2'd0, 0);
    xbytes = '{32'hAA}; xfull = '{1'b1};
    run_xfer(2'($urandom_range(0, 3)), 1);
    xbytes = '{32'h3C, 32'hAA}; xfull = '{1'b0, 1'b1};
    run_xfer(2'd3, 2);

    // Reset after five quad samples discards the partial transfer.
    start = 1'b1; mode = 2'd2; rx_len = LEN_W'(3);
    step();
    start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      sample_en = 1'b1; io_in = 4'($urandom);
      step();
    end
    sample_en = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr", fifo_wr_en, 0);
    chk("mid_rst_cnt", byte_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; io_in = 4'($urandom);
      settle();
      chk("mid_rst_no_wr", fifo_wr_en, 0);
      step();
    end
    sample_en = 1'b0;
    xbytes = '{32'h5E}; xfull = '{1'b0};
    run_xfer(2'd2, 1);

    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(0, 4);
      fill_random(len, 20);
      run_xfer(2'($urandom_range(0, 3)), len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_rx_deserializer.md
Name: spi_rx_deserializer

Overview:
- Receive-side shift stage of the Quad-SPI core.
- Samples the IO lines on sample strobes from the SCK generator in single, dual or quad mode, assembles MSB-first bytes, and pushes each byte into the 261-entry receive FIFO.
- Tracks the programmed transfer length, signals completion and flags overflow when the FIFO cannot accept a byte.

Parameters:
- LEN_W, 9, width of transfer length and byte counter.
- MAX_LEN, 261, largest legal rx_len; equals RX FIFO depth.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches mode and rx_len and begins transfer
- mode  in  2  0=single, 1=dual, 2=quad, 3=reserved (treated as single)
- rx_len  in  LEN_W  bytes to receive; 0 is legal
- sample_en  in  1  one-cycle strobe: IO lines valid this cycle
- io_in  in  4  SPI IO[3:0]
- fifo_full  in  1  RX FIFO full flag
- fifo_wr_en  out  1  one-cycle write strobe to RX FIFO
- fifo_data  out  8  byte to RX FIFO, valid with fifo_wr_en
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the last byte is pushed (or dropped)
- overflow  out  1  sticky: a byte met fifo_full; cleared by start or reset
- byte_cnt  out  LEN_W  bytes completed so far in the current transfer
- stall  out  1  request SCK hold (feature-dependent; 0 when the feature is absent)

Behaviour:
- Reset values: fifo_wr_en=0, fifo_data=0, busy=0, done=0, overflow=0, byte_cnt=0, stall=0. The shift register and bit counter clear.
- Reset mid-transfer: the next cycle returns to IDLE; the partial byte is discarded and no write is issued.
- FSM states: IDLE, SHIFT, PUSH, FINISH.
- IDLE:
  - start latches mode and rx_len, clears byte_cnt and overflow, and sets busy the next cycle.
  - If rx_len=0, go to FINISH; otherwise go to SHIFT.
- SHIFT, per sample_en:
  - Shift the register left by k bits, where k=1/2/4 for single/dual/quad.
  - Inserted bits: single inserts io_in[1] (MISO); dual inserts {io_in[1],io_in[0]}; quad inserts io_in[3:0].
  - After 8/4/2 samples respectively, go to PUSH.
  - sample_en is ignored outside SHIFT.
- PUSH, exactly one cycle after the final sample:
  - If !fifo_full: fifo_wr_en=1 and fifo_data=assembled byte for one cycle.
  - If fifo_full: no write and overflow<=1 (unless the stall feature applies).
  - byte_cnt increments.
  - Next state: FINISH if byte_cnt+1==latched length, else SHIFT.
- FINISH: done=1 for one cycle, busy<=0, return to IDLE.
- Latency: byte pushed 1 cycle after its last sample; done asserts 1 cycle after the last push.
- start while busy is ignored. Inputs mode and rx_len are sampled only at start.
- Back-to-back transfers: a start in the same cycle as done is ignored; start is accepted in IDLE from the next cycle.
- byte_cnt holds its final value after done until the next start.
- Lengths above MAX_LEN are accepted and counted modulo 2^LEN_W; software must not exceed MAX_LEN.

Optional Feature:
- Macro: SPI_RX_STALL_EN.
- Defined:
  - In PUSH with fifo_full, the FSM stays in PUSH with stall=1 and retries every cycle.
  - The write issues in the first cycle fifo_full=0, and stall drops the same cycle.
  - No data is lost and overflow never sets.
- Undefined: stall is tied 0; the byte is dropped and overflow is set as described above.

Decomposition:
- Shared package spi_pkg holds:
  - mode encodings SPI_MODE_SINGLE/DUAL/QUAD;
  - state encodings;
  - constant RX_FIFO_DEPTH=261;
  - bits-per-sample function.
- One natural sub-module: spi_rx_shifter (shift register plus bit counter, width-selectable insert, byte_ready pulse). The FSM, length tracking and FIFO handshake remain in the top.

Test Plan:
- Single mode, rx_len=2, IO1 sequence 1010_0101 then 1111_0000 -> writes 0xA5 then 0xF0, each 1 cycle after its 8th sample; done 1 cycle after the second write; byte_cnt=2.
- Quad mode, rx_len=3, nibbles 0x1,0x2,0x3,0x4,0x5,0x6 -> writes 0x12,0x34,0x56; done; overflow=0.
- Dual mode, rx_len=1, pairs 11,00,10,01 -> single write 0xC9; busy high from start+1 through done.
- rx_len=0 start -> no fifo_wr_en; done pulses 2 cycles after start; byte_cnt=0.
- fifo_full=1 during PUSH of byte 0xAA:
  - Without SPI_RX_STALL_EN: no write, overflow=1, transfer completes.
  - With it: stall=1 until fifo_full drops, then a single 0xAA write.
- reset asserted after 5 quad samples -> next cycle busy=0, no write; a new start with rx_len=1 receives a correct byte; a start pulse mid-transfer is ignored.
